// File: rtl/sum_fifo_pkg.sv
// Constants and the signed window-sum word shared by the accumulator,
// the sum FIFO and the feature consumer.
package sum_fifo_pkg;

    localparam int SUM_DATA_W = 38;
    localparam int SUM_DEPTH  = 16;
    localparam int SUM_DROP_W = 16;

    typedef logic signed [SUM_DATA_W-1:0] sum_t;

endpackage

// File: rtl/sum_fifo_mem.sv
// DEPTH x DATA_W dual-port RAM: synchronous write, asynchronous read so the
// FIFO head falls through in the same cycle the read pointer moves.
module sum_fifo_mem
    import sum_fifo_pkg::*;
#(
    parameter int DATA_W = SUM_DATA_W,
    parameter int DEPTH  = SUM_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sum_fifo.sv
// First-word-fall-through FIFO for completed window sums, with a sticky
// overflow flag and a saturating count of dropped pushes.
module sum_fifo
    import sum_fifo_pkg::*;
#(
    parameter int DATA_W = SUM_DATA_W,
    parameter int DEPTH  = SUM_DEPTH,
    parameter int DROP_W = SUM_DROP_W,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W:0]          level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt,
    input  logic                     clr_ovf
);

    logic [ADDR_W:0]     r_wr_ptr;
    logic [ADDR_W:0]     r_rd_ptr;
    logic                r_overflow;
    logic [DROP_W-1:0]   r_drop_cnt;

    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic [DATA_W-1:0]   w_rd_data;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                     (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

    assign w_pop  = !w_empty && out_ready;
    assign w_push = in_valid && (!w_full || w_pop);
    assign w_drop = in_valid && w_full && !w_pop;

    sum_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
        .i_wr_data (in_data),
        .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // A drop in the same cycle as clr_ovf wins: the flag stays set and the
    // count restarts at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clr_ovf) begin
                r_drop_cnt <= DROP_W'(1);
            end else if (!(&r_drop_cnt)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign out_data  = w_empty ? '0 : w_rd_data;
    assign out_valid = !w_empty;
    assign level     = r_wr_ptr - r_rd_ptr;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_sum_fifo.sv
// Directed bench for sum_fifo at DEPTH=4: basic push/pop, overflow, full
// push-with-pop, pointer wrap with extreme values, drop saturation, reset.
module tb_sum_fifo;
    import sum_fifo_pkg::*;

    localparam int DW    = SUM_DATA_W;
    localparam int DEP   = 4;
    localparam int AW    = $clog2(DEP);
    localparam int DRW   = SUM_DROP_W;

    logic            clk = 1'b0;
    logic            rst;
    sum_t            in_data;
    logic            in_valid;
    sum_t            out_data;
    logic            out_valid;
    logic            out_ready;
    logic [AW:0]     level;
    logic            full;
    logic            empty;
    logic            overflow;
    logic [DRW-1:0]  drop_cnt;
    logic            clr_ovf;

    int n_assert = 0;
    int n_fail   = 0;

    sum_t q[$];

    always #5 clk = ~clk;

    sum_fifo #(
        .DATA_W (DW),
        .DEPTH  (DEP),
        .DROP_W (DRW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .clr_ovf   (clr_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input sum_t obs, input sum_t exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic sum_t wrap_val(input int i);
        sum_t v;
        if (i == 4 || i == 13)      v = {1'b0, {(DW-1){1'b1}}};
        else if (i == 9 || i == 17) v = {1'b1, {(DW-1){1'b0}}};
        else                        v = sum_t'(i * 12345 - 50000);
        return v;
    endfunction

    initial begin
        bit   m_pop;
        bit   m_full;
        int   m_drops;
        sum_t v;

        rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_level", 32'(level), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk_d("rst_data", out_data, 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_drop", 32'(drop_cnt), 0);

        // Two separate strobes, consumer stalled
        in_data = -5; in_valid = 1'b1; tick();
        in_valid = 1'b0; tick();
        in_data = 7; in_valid = 1'b1; tick();
        in_valid = 1'b0;
        chk("two_level", 32'(level), 2);
        chk_d("two_head", out_data, -5);
        chk("two_valid", 32'(out_valid), 1);
        out_ready = 1'b1; tick();
        chk_d("pop1_head", out_data, 7);
        chk("pop1_level", 32'(level), 1);
        tick();
        out_ready = 1'b0;
        chk("pop2_empty", 32'(empty), 1);
        chk("pop2_valid", 32'(out_valid), 0);
        chk_d("pop2_data", out_data, 0);

        // Fill, then a dropped push
        for (int i = 1; i <= 4; i++) begin
            in_data = sum_t'(i); in_valid = 1'b1; tick();
        end
        chk("fill_full", 32'(full), 1);
        chk("fill_level", 32'(level), 4);
        in_data = 99; tick();
        in_valid = 1'b0;
        chk("drop_full", 32'(full), 1);
        chk("drop_ovf", 32'(overflow), 1);
        chk("drop_cnt", 32'(drop_cnt), 1);
        chk_d("drop_head", out_data, 1);

        // Full with simultaneous pop: both happen
        in_data = 42; in_valid = 1'b1; out_ready = 1'b1; tick();
        in_valid = 1'b0;
        chk("fpp_level", 32'(level), 4);
        chk_d("fpp_head", out_data, 2);
        chk("fpp_ovf", 32'(overflow), 1);
        chk("fpp_drop", 32'(drop_cnt), 1);
        tick(); chk_d("drain_3", out_data, 3);
        tick(); chk_d("drain_4", out_data, 4);
        tick(); chk_d("drain_42", out_data, 42);
        tick(); chk("drain_empty", 32'(empty), 1);
        out_ready = 1'b0;

        clr_ovf = 1'b1; tick();
        clr_ovf = 1'b0;
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_drop", 32'(drop_cnt), 0);

        // Interleaved traffic across pointer wrap, checked against a queue
        m_drops = 0;
        for (int i = 0; i < 20; i++) begin
            v = wrap_val(i);
            in_data   = v;
            in_valid  = 1'b1;
            out_ready = (i % 5 != 0);
            m_pop  = out_ready && (q.size() > 0);
            m_full = (q.size() == DEP);
            if (m_pop) void'(q.pop_front());
            if (!m_full || m_pop) q.push_back(v);
            else m_drops++;
            tick();
            chk("wrap_valid", 32'(out_valid), 32'(q.size() > 0));
            chk_d("wrap_data", out_data, (q.size() > 0) ? q[0] : sum_t'(0));
            chk("wrap_level", 32'(level), 32'(q.size()));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        while (q.size() > 0) begin
            void'(q.pop_front());
            tick();
            chk_d("wrap_drain", out_data, (q.size() > 0) ? q[0] : sum_t'(0));
        end
        out_ready = 1'b0;
        chk("wrap_empty", 32'(empty), 1);
        chk("wrap_drops", 32'(drop_cnt), 32'(m_drops));

        clr_ovf = 1'b1; tick();
        clr_ovf = 1'b0;

        // Saturate the drop counter
        for (int i = 0; i < DEP; i++) begin
            in_data = sum_t'(100 + i); in_valid = 1'b1; tick();
        end
        for (int k = 0; k < 65535; k++) tick();
        chk("sat_cnt", 32'(drop_cnt), 32'hFFFF);
        tick();
        chk("sat_hold", 32'(drop_cnt), 32'hFFFF);
        chk("sat_ovf", 32'(overflow), 1);
        clr_ovf = 1'b1; tick();
        clr_ovf = 1'b0; in_valid = 1'b0;
        chk("clrdrop_ovf", 32'(overflow), 1);
        chk("clrdrop_cnt", 32'(drop_cnt), 1);
        chk_d("sat_head", out_data, 100);

        // Reset mid-stream with three entries held
        out_ready = 1'b1; tick();
        out_ready = 1'b0;
        chk("pre_rst_level", 32'(level), 3);
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("mrst_level", 32'(level), 0);
        chk("mrst_empty", 32'(empty), 1);
        chk("mrst_valid", 32'(out_valid), 0);
        chk("mrst_ovf", 32'(overflow), 0);
        in_data = 11; in_valid = 1'b1; tick();
        in_valid = 1'b0;
        chk_d("post_rst_head", out_data, 11);
        chk("post_rst_level", 32'(level), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
